// File: rtl/sha3_msg_sender.sv
// Input-side driver for the sha3_high_throughput core: streams an LFSR message of msg_len bytes,
// waits for the digest, captures it and pulses a core reset before returning to idle.
module sha3_msg_sender #(
  parameter int          LEN_W   = 16,
  parameter logic [63:0] SEED    = 64'h0123_4567_89AB_CDEF,
  parameter int          TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic [63:0]      in,
  output logic             in_ready,
  output logic             is_last,
  output logic [2:0]       byte_num,
  input  logic             buffer_full,
  input  logic [511:0]     out,
  input  logic             out_ready,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic [511:0]     digest,
  output logic             digest_valid,
  output logic             error
);

  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
  localparam int          TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_CLR} state_t;

  state_t           state;
  logic [63:0]      lfsr;
  logic [63:0]      lfsr_nxt;
  logic [LEN_W-4:0] words_left;
  logic [2:0]       rem;
  logic [TW-1:0]    timer;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 64'd0);
  endfunction

  // Keep the upper r bytes of the word; r = 0 leaves nothing.
  function automatic logic [63:0] tail_word(input logic [63:0] s, input logic [2:0] r);
    return s & ~({64{1'b1}} >> {r, 3'b000});
  endfunction

  assign lfsr_nxt = lfsr_step(lfsr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      lfsr         <= SEED;
      words_left   <= '0;
      rem          <= '0;
      timer        <= '0;
      in           <= '0;
      in_ready     <= 1'b0;
      is_last      <= 1'b0;
      byte_num     <= '0;
      core_reset   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_SEND;
            busy         <= 1'b1;
            digest_valid <= 1'b0;
            error        <= 1'b0;
            rem          <= msg_len[2:0];
            words_left   <= msg_len[LEN_W-1:3];
            in_ready     <= 1'b1;
            if (msg_len[LEN_W-1:3] == '0) begin
              in       <= tail_word(lfsr, msg_len[2:0]);
              is_last  <= 1'b1;
              byte_num <= msg_len[2:0];
            end else begin
              in       <= lfsr;
              is_last  <= 1'b0;
              byte_num <= '0;
            end
          end
        end
        S_SEND: begin
          if (!buffer_full) begin
            lfsr <= lfsr_nxt;
            if (is_last) begin
              in_ready <= 1'b0;
              in       <= '0;
              is_last  <= 1'b0;
              byte_num <= '0;
              timer    <= '0;
              state    <= S_WAIT;
            end else begin
              words_left <= words_left - 1'b1;
              // The word after the last full one is the partial tail.
              if (words_left == (LEN_W-3)'(1)) begin
                in       <= tail_word(lfsr_nxt, rem);
                is_last  <= 1'b1;
                byte_num <= rem;
              end else begin
                in <= lfsr_nxt;
              end
            end
          end
        end
        S_WAIT: begin
          if (out_ready) begin
            digest       <= out;
            digest_valid <= 1'b1;
            done         <= 1'b1;
            state        <= S_CLR;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= S_CLR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CLR: begin
          // First CLR cycle raises core_reset, second drops it and frees the block.
          if (!core_reset) begin
            core_reset <= 1'b1;
          end else begin
            core_reset <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sha3_msg_sender.md
# sha3_msg_sender

Input-side driver for the `sha3_high_throughput` core. On `start` it streams a pseudo-random message of `msg_len` bytes into the core's 64-bit word interface, honouring `buffer_full` backpressure and generating `is_last`/`byte_num`. It then waits for `out_ready`, captures the 512-bit digest, and pulses a core reset so the core is ready for the next message. It sits beside the core in out-of-context test tops and replaces free-running RNG stimulus with deterministic, length-controlled messages.

## Interface
- `LEN_W`, 16, width of `msg_len` in bytes.
- `SEED`, 64'h0123_4567_89AB_CDEF, LFSR reset value; must be nonzero.
- `TIMEOUT`, 4096, maximum cycles in WAIT_DIGEST before `error` is set.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a message; sampled only in IDLE.
- `msg_len` in LEN_W: message length in bytes; sampled with `start`.
- `in` out 64: data word to the core; valid bytes are MSB-first.
- `in_ready` out 1: word on `in` is valid.
- `is_last` out 1: current word is the final word.
- `byte_num` out 3: valid byte count of the final word (0–7); 0 when `is_last`=0.
- `buffer_full` in 1: core backpressure.
- `out` in 512: core digest.
- `out_ready` in 1: core digest valid (level).
- `core_reset` out 1: one-cycle reset pulse to the core, OR'd with `reset` at the top level.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the digest is captured.
- `digest` out 512: captured digest.
- `digest_valid` out 1: `digest` holds a result; cleared on the next accepted `start`.
- `error` out 1: sticky timeout flag; cleared by `reset` or an accepted `start`.

## Operation
- **Transfer rule:** a word is consumed on any rising edge where `in_ready`=1 and `buffer_full`=0. While `buffer_full`=1, `in`, `is_last` and `byte_num` hold stable.
- **Word count:** full = `msg_len`>>3, r = `msg_len`[2:0]. The sender issues `full` words with `is_last`=0, then exactly one word with `is_last`=1 and `byte_num`=r. Total transfers = full+1.
- **Final-word payload:** the upper r bytes come from the LFSR and the lower 8−r bytes are zero. When r=0, the final word is all zero.
- **Data source:** 64-bit Galois LFSR, taps 64'hD800_0000_0000_0000, shift right with XOR when bit0=1.
  - Loaded with `SEED` on `reset` only.
  - The current state is presented as the word; the LFSR advances once per transfer.
  - The sequence continues across messages.
- **FSM states:**
  - IDLE: on `start`, latch `msg_len`, load the word counter, clear `digest_valid` and `error`, go to SEND.
  - SEND: `in_ready`=1. On the transfer of the `is_last` word, go to WAIT.
  - WAIT: `in_ready`=0 and the timeout counter runs.
    - First cycle with `out_ready`=1: latch `out` into `digest`, set `digest_valid`, pulse `done`, go to CLR.
    - Counter reaching `TIMEOUT`: set `error`, go to CLR with no capture.
  - CLR: `core_reset`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- `msg_len` changes after the accepted `start` have no effect on the message.

## Timing
- **Reset values:**
  - `in`=0, `in_ready`=0, `is_last`=0, `byte_num`=0, `core_reset`=0.
  - `busy`=0, `done`=0, `digest`=0, `digest_valid`=0, `error`=0.
  - FSM in IDLE, LFSR = `SEED`.
- All outputs are registered.
- **Entering SEND:** `start` accepted at edge N puts `in_ready`=1 with the first word from edge N+1.
- **Throughput:** with `buffer_full`=0 throughout, the message occupies full+1 consecutive cycles, one word per cycle with no bubbles.
- **Final transfer:** after the `is_last` transfer, `in_ready` drops on the next edge.
- **Digest capture:** `out_ready` rising at edge M yields `done`=1 and `digest_valid`=1 from edge M+1. `core_reset`=1 during the following cycle, and `busy` falls one cycle after that.
- **Reset mid-operation:** every output returns to its reset value at the next edge, the message is abandoned, and the LFSR reloads `SEED`.
- **Stale `out_ready`:** `out_ready` asserted in IDLE or SEND is ignored.

## Test plan
- `msg_len`=8, no backpressure: 2 transfers. Word 0 = `SEED` with `is_last`=0; word 1 = 0 with `is_last`=1, `byte_num`=0. `in_ready` is high for exactly 2 cycles.
- `msg_len`=3: 1 transfer with `is_last`=1, `byte_num`=3. `in` = `SEED` with bits [39:0] zeroed (64'h0123_4500_0000_0000).
- `msg_len`=20 with `buffer_full` held high for 5 cycles during the 2nd word: 3 transfers, word stable while stalled, `byte_num`=4 on the last word, LFSR advanced exactly 3 times.
- Hold `out_ready`=1 for 3 cycles after the last transfer with `out`=512'hA5…A5: the single `done` pulse carries `digest`=A5…A5, followed by one `core_reset` cycle, then return to IDLE.
- Never assert `out_ready`, `TIMEOUT`=16: `error`=1 after 16 WAIT cycles, `digest_valid`=0, `core_reset` pulses once, `error` clears on the next `start`.
- Assert `reset` during SEND, then start `msg_len`=8: the first word equals `SEED` again; a `start` pulsed while `busy`=1 is ignored.
